// File: rtl/data_array_port_arbiter.sv
// Port owner for a single-ported 256x64 data-array SRAM: zero-fills after reset, then
// arbitrates reads and writes (write priority, bounded read starvation) with 1-cycle read data.
module data_array_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] init_idx;
    logic [CNT_W-1:0]  starve_cnt;
    logic              starve;
    logic              wr_fire;
    logic              rd_fire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= INIT;
            init_idx      <= '0;
            init_done     <= 1'b0;
            starve_cnt    <= '0;
            rd_resp_valid <= 1'b0;
        end else begin
            state         <= state_next;
            rd_resp_valid <= rd_fire;
            if (state == INIT) begin
                init_idx <= init_idx + 1'b1;
                if (init_idx == LAST_ROW)
                    init_done <= 1'b1;
            end
            // Counts write grants that overtook a waiting read; any read grant or idle read clears it.
            if (state == RUN) begin
                if (rd_fire || !rd_valid)
                    starve_cnt <= '0;
                else if (wr_fire && !starve)
                    starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        rd_ready   = 1'b0;
        wr_fire    = 1'b0;
        rd_fire    = 1'b0;
        mem_en     = 1'b0;
        mem_wmode  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        starve     = (starve_cnt == LIMIT);
        // Macro is held quiet while reset is asserted so no stray write lands mid-reset.
        if (!reset) begin
            case (state)
                INIT: begin
                    mem_en    = 1'b1;
                    mem_wmode = 1'b1;
                    mem_addr  = init_idx;
                    if (init_idx == LAST_ROW)
                        state_next = RUN;
                end
                RUN: begin
                    wr_ready = !(rd_valid && starve);
                    rd_ready = !wr_valid || starve;
                    wr_fire  = wr_valid && wr_ready;
                    rd_fire  = rd_valid && rd_ready;
                    mem_en   = wr_fire || rd_fire;
                    if (wr_fire) begin
                        mem_wmode = 1'b1;
                        mem_addr  = wr_addr;
                        mem_wdata = wr_data;
                    end else if (rd_fire) begin
                        mem_addr  = rd_addr;
                    end
                end
                default: state_next = INIT;
            endcase
        end
    end

    assign rd_resp_data = rd_resp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_data_array_port_arbiter.sv
// Self-checking bench for data_array_port_arbiter: behavioural SRAM, fixed vector table,
// starvation/reset sequences and randomized traffic against a high-level reference model.
module tb_data_array_port_arbiter;

    localparam int LIMIT = 4;
    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0, rd_valid = 1'b0;
    logic        wr_ready, rd_ready;
    logic [7:0]  wr_addr = '0, rd_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rd_resp_valid, init_done, mem_en, mem_wmode;
    logic [63:0] rd_resp_data, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    int checks = 0;
    int errors = 0;

    data_array_port_arbiter dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .init_done(init_done),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_wmode(mem_wmode),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural macro, preloaded with garbage so the zero-fill is observable.
    logic [63:0] sram [DEPTH];
    logic [63:0] sram_rdata = '0;
    assign mem_rdata = sram_rdata;
    initial for (int i = 0; i < DEPTH; i++) sram[i] = {$urandom, $urandom};
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_wmode) sram[mem_addr] <= mem_wdata;
            else           sram_rdata     <= sram[mem_addr];
        end
    end

    // Reference model: expected contents, cycles the current read has been blocked, pending response.
    logic [63:0] exp_mem [DEPTH];
    int          waited;
    logic        pend_valid;
    logic [63:0] pend_data;
    logic        m_wr_ready, m_rd_ready, m_resp_valid;
    logic [63:0] m_resp_data;

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        waited     = 0;
        pend_valid = 1'b0;
        pend_data  = '0;
    endtask

    task automatic modelExpect();
        m_wr_ready   = !(rd_valid && waited >= LIMIT);
        m_rd_ready   = !wr_valid || waited >= LIMIT;
        m_resp_valid = pend_valid;
        m_resp_data  = pend_valid ? pend_data : 64'h0;
    endtask

    task automatic modelAdvance();
        logic wf, rf;
        wf = wr_valid && m_wr_ready;
        rf = rd_valid && m_rd_ready;
        pend_valid = rf;
        pend_data  = exp_mem[rd_addr];
        if (wf) exp_mem[wr_addr] = wr_data;
        if (rf || !rd_valid) waited = 0;
        else if (wf && waited < LIMIT) waited = waited + 1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic rv, input logic [7:0] wa,
                                 input logic [63:0] wd, input logic [7:0] ra);
        wr_valid = wv; rd_valid = rv; wr_addr = wa; wr_data = wd; rd_addr = ra;
        #1;
    endtask

    task automatic checkModel(input string tag);
        modelExpect();
        checkOutput({tag, "_wr_ready"}, 64'(wr_ready), 64'(m_wr_ready));
        checkOutput({tag, "_rd_ready"}, 64'(rd_ready), 64'(m_rd_ready));
        checkOutput({tag, "_resp_valid"}, 64'(rd_resp_valid), 64'(m_resp_valid));
        checkOutput({tag, "_resp_data"}, rd_resp_data, m_resp_data);
    endtask

    // Entered at the negedge of the first INIT cycle with inputs idle.
    task automatic checkInit();
        applyStimulus(1'b0, 1'b0, 8'h0, 64'h0, 8'h0);
        for (int k = 0; k < DEPTH; k++) begin
            checkOutput("init_addr", 64'(mem_addr), 64'(k));
            checkOutput("init_flags",
                        {58'h0, mem_en, mem_wmode, mem_wdata == 64'h0, wr_ready, rd_ready, init_done},
                        {58'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
            @(negedge clock);
            #1;
        end
        checkOutput("init_done_rise", 64'(init_done), 64'h1);
        checkOutput("init_sram_row", sram[8'hFF], 64'h0);
        modelReset();
    endtask

    typedef struct {
        logic        wv, rv;
        logic [7:0]  wa, ra;
        logic [63:0] wd;
        logic        ewr, erd, erv;
        logic [63:0] edata;
    } vec_t;
    vec_t vecs [8];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h12, 8'h00, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, 1'b0, 64'h0};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h12, 64'h0,                 1'b1, 1'b1, 1'b0, 64'h0};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 8'h00, 64'h0,                 1'b1, 1'b1, 1'b1, 64'hDEADBEEF_CAFEF00D};
        vecs[3] = '{1'b1, 1'b1, 8'h20, 8'hFF, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 1'b0, 64'h0};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'hFF, 64'h0,                 1'b1, 1'b1, 1'b0, 64'h0};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h20, 64'h0,                 1'b1, 1'b1, 1'b1, 64'h0};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 64'h0,                 1'b1, 1'b1, 1'b1, 64'h1111_2222_3333_4444};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 64'h0,                 1'b1, 1'b1, 1'b0, 64'h0};

        modelReset();
        @(negedge clock);
        @(negedge clock);
        #1;
        checkOutput("rst_mem_en", 64'(mem_en), 64'h0);
        checkOutput("rst_readies", {62'h0, wr_ready, rd_ready}, 64'h0);
        checkOutput("rst_resp", {63'h0, rd_resp_valid}, 64'h0);
        checkOutput("rst_init_done", 64'(init_done), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        checkInit();

        $display("[TB] directed vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].wv, vecs[i].rv, vecs[i].wa, vecs[i].wd, vecs[i].ra);
            modelExpect();
            checkOutput($sformatf("vec%0d_wr_ready", i), 64'(wr_ready), 64'(vecs[i].ewr));
            checkOutput($sformatf("vec%0d_rd_ready", i), 64'(rd_ready), 64'(vecs[i].erd));
            checkOutput($sformatf("vec%0d_resp_valid", i), 64'(rd_resp_valid), 64'(vecs[i].erv));
            checkOutput($sformatf("vec%0d_resp_data", i), rd_resp_data, vecs[i].edata);
            modelAdvance();
            @(negedge clock);
        end

        $display("[TB] starvation sequence");
        for (int i = 0; i < 3 * (LIMIT + 1); i++) begin
            applyStimulus(1'b1, 1'b1, 8'(i + 8'h40), {$urandom, $urandom}, 8'h12);
            checkOutput("starve_rd_ready", 64'(rd_ready), 64'((i % (LIMIT + 1)) == LIMIT));
            checkOutput("starve_wr_ready", 64'(wr_ready), 64'((i % (LIMIT + 1)) != LIMIT));
            checkModel("starve");
            modelAdvance();
            @(negedge clock);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)),
                          {$urandom, $urandom}, 8'($urandom_range(0, 15)));
            checkModel("rand");
            modelAdvance();
            @(negedge clock);
        end

        $display("[TB] reset after read accept");
        applyStimulus(1'b0, 1'b1, 8'h0, 64'h0, 8'h12);
        checkOutput("pre_rst_rd_ready", 64'(rd_ready), 64'h1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h0, 64'h0, 8'h0);
        checkOutput("midrst_resp_valid", 64'(rd_resp_valid), 64'h0);
        checkOutput("midrst_init_done", 64'(init_done), 64'h0);
        checkOutput("midrst_mem_en", 64'(mem_en), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        checkInit();

        applyStimulus(1'b0, 1'b1, 8'h0, 64'h0, 8'h12);
        checkModel("post_rst_read");
        modelAdvance();
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 8'h0, 64'h0, 8'h0);
        checkOutput("post_rst_resp_valid", 64'(rd_resp_valid), 64'h1);
        checkOutput("post_rst_resp_data", rd_resp_data, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_array_port_arbiter.md
# data_array_port_arbiter

Controller that owns the single read/write port of one 256x64 data-array SRAM macro and shares it between a read requester and a write requester. After reset it zero-fills every row, then arbitrates per cycle with write priority and a bounded anti-starvation guarantee for reads, and returns read data with fixed one-cycle latency. It sits between the cache data-path pipelines and the `RW0_*` port of the macro.

## Interface
Parameters:
- `ADDR_W`, 8, macro address width; depth `DEPTH = 2**ADDR_W`.
- `DATA_W`, 64, data word width.
- `STARVE_LIMIT`, 4, max consecutive write grants while a read waits (≥1).

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted this cycle when `wr_valid & wr_ready`.
- `wr_addr`  in  ADDR_W  write row.
- `wr_data`  in  DATA_W  write word.
- `rd_valid`  in  1  read request.
- `rd_ready`  out  1  read accepted when `rd_valid & rd_ready`.
- `rd_addr`  in  ADDR_W  read row.
- `rd_resp_valid`  out  1  read data valid (one-cycle pulse per accepted read).
- `rd_resp_data`  out  DATA_W  read data.
- `init_done`  out  1  high once zero-fill completes.
- `mem_addr`  out  ADDR_W  to `RW0_addr`.
- `mem_en`  out  1  to `RW0_en`.
- `mem_wmode`  out  1  to `RW0_wmode` (1 = write).
- `mem_wdata`  out  DATA_W  to `RW0_wdata`.
- `mem_rdata`  in  DATA_W  from `RW0_rdata`; valid the cycle after a read-enable.

## Operation
- FSM states: INIT, RUN. Reset → INIT, `init_idx = 0`, `starve_cnt = 0`.
- INIT: each cycle `mem_en=1`, `mem_wmode=1`, `mem_addr=init_idx`, `mem_wdata=0`; `init_idx++`. After writing `DEPTH-1` → RUN, `init_done=1` (registered, stays 1 until reset). `wr_ready=rd_ready=0` throughout INIT.
- RUN arbitration (combinational ready): `starve = (starve_cnt == STARVE_LIMIT)`.
  - `wr_ready = !(rd_valid & starve)`.
  - `rd_ready = !wr_valid | starve`.
  - Exactly one of `wr_fire`, `rd_fire` possible per cycle.
- Macro drive (combinational from fire): `mem_en = wr_fire | rd_fire`; `mem_wmode = wr_fire`; `mem_addr` = winner's address; `mem_wdata = wr_data` on write, else 0. Idle: all macro outputs 0.
- `starve_cnt`: if `wr_fire & rd_valid` → +1 (saturates at `STARVE_LIMIT`); if `rd_fire` or `!rd_valid` → 0; else hold.
- Response: `rd_resp_valid` = registered `rd_fire`; `rd_resp_data = rd_resp_valid ? mem_rdata : 0`. No backpressure on responses.
- Requester inputs are sampled only on the fire cycle; stable-until-ready is the requester's obligation.

## Timing
- Reset values: `wr_ready=0`, `rd_ready=0`, `rd_resp_valid=0`, `rd_resp_data=0`, `init_done=0`, `mem_en=1` and `mem_wmode=1` with `mem_addr=0` in the first INIT cycle (during reset assertion macro outputs are 0).
- Zero-fill takes exactly `DEPTH` cycles (256 default); first request accepted on cycle `DEPTH` after reset release.
- Read latency: accept in cycle N → `rd_resp_valid` in N+1.
- Write in N, read same row in N+1 → response in N+2 carries new data.
- Back-to-back reads: one per cycle, responses one per cycle.
- Worst-case read wait under continuous writes: `STARVE_LIMIT` cycles, read granted on the next.
- Reset mid-operation: FSM returns to INIT immediately, pending response dropped (`rd_resp_valid=0`), zero-fill restarts at row 0.

## Test plan
- Reset release → 256 cycles of `mem_en=1, mem_wmode=1, mem_wdata=0`, addr 0..255; `init_done` rises cycle 256; readies 0 until then.
- Write addr 0x12 data 0xDEADBEEF_CAFEF00D, next cycle read 0x12 → `rd_resp_valid` one cycle after read accept, data 0xDEADBEEF_CAFEF00D.
- Same-cycle `wr_valid` and `rd_valid` (starve_cnt=0) → write wins, `rd_ready=0`, read accepted next cycle when write drops.
- Continuous `wr_valid` plus steady `rd_valid`, `STARVE_LIMIT=4` → 4 write grants, 5th cycle read granted with `wr_ready=0`, then writes resume; pattern repeats.
- Read of never-written row 0xFF after init → response data 0.
- Assert `reset` one cycle after a read accept → no `rd_resp_valid`, `init_done=0`, zero-fill restarts at addr 0.
